// File: rtl/eight_bit_comp_pkg.sv
// Shared definitions for the registered magnitude comparator: default width,
// the three-flag result encoding and the MSB-first merge used by the tree.
package eight_bit_comp_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_t;

   // Combine a more-significant result with a less-significant one: the lower
   // slice only decides when everything above it is equal.
   function automatic cmp_t cmp_merge(input cmp_t hi, input cmp_t lo);
      cmp_t res;
      res.gt = hi.gt | (hi.eq & lo.gt);
      res.eq = hi.eq & lo.eq;
      res.lt = hi.lt | (hi.eq & lo.lt);
      return res;
   endfunction

endpackage

// File: rtl/eight_bit_comp_comp2_cell.sv
// 2-bit unsigned comparator cell; the leaf of the comparison tree.
module comp2_cell
   import eight_bit_comp_pkg::*;
(
   input  logic [1:0] a,
   input  logic [1:0] b,
   output cmp_t       res
);

   logic hi_eq;

   assign hi_eq  = ~(a[1] ^ b[1]);
   assign res.gt = (a[1] & ~b[1]) | (hi_eq & a[0] & ~b[0]);
   assign res.lt = (~a[1] & b[1]) | (hi_eq & ~a[0] & b[0]);
   assign res.eq = hi_eq & ~(a[0] ^ b[0]);

endmodule

// File: rtl/eight_bit_comp.sv
// Registered unsigned magnitude comparator: combinational 2-bit cell tree,
// merged MSB-first, captured into one-hot G/Q/L flags every clock.
module eight_bit_comp
   import eight_bit_comp_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             G,
   output logic             Q,
   output logic             L
);

   localparam int NCELL = WIDTH / 2;

   cmp_t cell_res [NCELL];
   cmp_t acc      [NCELL];

   genvar gi;
   generate
      for (gi = 0; gi < NCELL; gi++) begin : g_cell
         comp2_cell u_cell (
            .a   (a[2*gi+1 -: 2]),
            .b   (b[2*gi+1 -: 2]),
            .res (cell_res[gi])
         );
      end

      // acc[i] holds the verdict for bits WIDTH-1 down to 2*i.
      assign acc[NCELL-1] = cell_res[NCELL-1];
      for (gi = NCELL - 2; gi >= 0; gi--) begin : g_merge
         assign acc[gi] = cmp_merge(acc[gi+1], cell_res[gi]);
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         G <= 1'b0;
         Q <= 1'b0;
         L <= 1'b0;
      end else begin
         G <= acc[0].gt;
         Q <= acc[0].eq;
         L <= acc[0].lt;
      end
   end

endmodule

// File: tb/tb_eight_bit_comp.sv
// Self-checking bench for eight_bit_comp: directed table, async reset,
// latency sequence, exhaustive sweep and random pairs against a model.
module tb_eight_bit_comp;

   logic       clk;
   logic       reset;
   logic [7:0] a;
   logic [7:0] b;
   logic       G;
   logic       Q;
   logic       L;

   int errors = 0;
   int checks = 0;

   eight_bit_comp #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .G     (G),
      .Q     (Q),
      .L     (L)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] exp; // {G,Q,L}
   } vec_t;

   vec_t vecs [9];

   // Reference: the unsigned relation expressed directly as integers.
   function automatic logic [2:0] model(input int x, input int y);
      return {x > y, x == y, x < y};
   endfunction

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got GQL=%b expected %b (a=%02h b=%02h)", name, act, exp, a, b);
      end
   endtask

   task automatic apply_and_check(input string name, input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      a = x;
      b = y;
      @(posedge clk);
      #1;
      check(name, {G, Q, L}, model(int'(x), int'(y)));
   endtask

   initial begin
      vecs[0] = '{8'h00, 8'h00, 3'b010};
      vecs[1] = '{8'h18, 8'h18, 3'b010};
      vecs[2] = '{8'hFF, 8'hFF, 3'b010};
      vecs[3] = '{8'h00, 8'h01, 3'b001};
      vecs[4] = '{8'h08, 8'h10, 3'b001};
      vecs[5] = '{8'h80, 8'h00, 3'b100};
      vecs[6] = '{8'h48, 8'h18, 3'b100};
      vecs[7] = '{8'h80, 8'h7F, 3'b100};
      vecs[8] = '{8'h00, 8'hFF, 3'b001};

      // Power-up reset with arbitrary operands
      reset = 1'b1;
      a = 8'h5A;
      b = 8'h3C;
      #2;
      check("reset_initial", {G, Q, L}, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", {G, Q, L}, 3'b000);
      @(negedge clk);
      reset = 1'b0;
      a = 8'h00;
      b = 8'h00;
      #1;
      check("release_before_edge", {G, Q, L}, 3'b000);
      @(posedge clk);
      #1;
      check("release_first_edge", {G, Q, L}, 3'b010);

      // Directed table
      foreach (vecs[i]) begin
         @(negedge clk);
         a = vecs[i].a;
         b = vecs[i].b;
         @(posedge clk);
         #1;
         check($sformatf("table_%0d", i), {G, Q, L}, vecs[i].exp);
      end

      // Back-to-back: outputs hold the previous verdict until the next edge
      begin
         logic [7:0] sa [3];
         logic [7:0] sb [3];
         logic [2:0] se [3];
         logic [2:0] prev;
         sa[0] = 8'h00; sb[0] = 8'h01; se[0] = 3'b001;
         sa[1] = 8'h80; sb[1] = 8'h00; se[1] = 3'b100;
         sa[2] = 8'h18; sb[2] = 8'h18; se[2] = 3'b010;
         prev = vecs[8].exp;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = sa[i];
            b = sb[i];
            #1;
            check($sformatf("b2b_hold_%0d", i), {G, Q, L}, prev);
            @(posedge clk);
            #1;
            check($sformatf("b2b_new_%0d", i), {G, Q, L}, se[i]);
            prev = se[i];
         end
      end

      // Mid-stream async reset between edges discards the pending result
      @(negedge clk);
      a = 8'hF0;
      b = 8'h0F;
      #2;
      reset = 1'b1;
      #1;
      check("midreset_immediate", {G, Q, L}, 3'b000);
      @(posedge clk);
      #1;
      check("midreset_held", {G, Q, L}, 3'b000);
      @(negedge clk);
      reset = 1'b0;
      a = 8'h01;
      b = 8'h02;
      @(posedge clk);
      #1;
      check("midreset_recover", {G, Q, L}, 3'b001);

      // Exhaustive sweep: relation plus one-hot every cycle
      for (int x = 0; x < 256; x++) begin
         for (int y = 0; y < 256; y++) begin
            apply_and_check("sweep", x[7:0], y[7:0]);
            checks++;
            if (!$onehot({G, Q, L})) begin
               errors++;
               $display("FAIL sweep_onehot: got GQL=%b expected one-hot (a=%02h b=%02h)", {G, Q, L}, a, b);
            end
         end
      end

      // Random pairs, a quarter of them forced equal
      for (int i = 0; i < 500; i++) begin
         logic [7:0] rx;
         logic [7:0] ry;
         rx = 8'($urandom);
         ry = ($urandom_range(0, 3) == 0) ? rx : 8'($urandom);
         apply_and_check("random", rx, ry);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
